lbp_img_mem: RTL and testbench
==============================

# lbp_img_mem

Image-side memory responder for the LBP engine. Holds one IMG_W x IMG_H 8-bit gray image, loaded by raster-order streaming. Serves the engine's gray_addr/gray_req/gray_ready/gray_data read protocol and captures every lbp_addr/lbp_valid/lbp_data write into a result memory. Sits between the host/testbench and the LBP core, and exposes a readback port for checking results once the engine asserts finish.

## Interface
- IMG_W, 128, image width in pixels (power of two)
- IMG_H, 128, image height in pixels
- AW, 14, address width; log2(IMG_W*IMG_H)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  load_data valid
- load_data  in  8  gray pixel, raster order
- load_ready  out  1  block accepts load pixels
- gray_req  in  1  engine read request
- gray_addr  in  AW  engine read address
- gray_ready  out  1  image loaded; reads served
- gray_data  out  8  gray pixel at gray_addr
- lbp_valid  in  1  engine write strobe
- lbp_addr  in  AW  result address
- lbp_data  in  8  LBP code
- finish  in  1  engine completion
- rd_addr  in  AW  result readback address
- rd_data  out  8  result readback data
- wr_count  out  AW+1  number of accepted LBP writes
- done  out  1  finish observed; results frozen
- err  out  1  sticky protocol error

## Operation
- Reset is synchronous, active-high. FSM states: LOAD, SERVE, DONE. Reset enters LOAD.
- Reset clears the load counter, wr_count, done, and err. It does not clear gray memory contents. It clears result memory to 0 (8'h00 at every address, via a clear sweep or a valid-bit array).
- LOAD:
  - load_ready=1, gray_ready=0.
  - Each cycle with load_valid=1, writes gray_mem[ld_cnt]<=load_data and increments ld_cnt.
  - On the write of address IMG_W*IMG_H-1, moves to SERVE next cycle. ld_cnt wraps to 0.
- SERVE:
  - load_ready=0, gray_ready=1.
  - gray_data=gray_mem[gray_addr] combinationally while gray_ready=1 and gray_req=1; 8'h00 otherwise. The engine samples gray_data on the edge after it drives gray_addr.
  - lbp_valid=1: lbp_mem[lbp_addr]<=lbp_data at that edge, and wr_count+1. Repeated addresses overwrite; each still counts.
  - finish=1: moves to DONE next cycle. A write presented in the same cycle as finish is accepted.
- DONE:
  - gray_ready=0, done=1, load_ready=0. Writes are ignored.
  - Only reset leaves DONE.
- err (sticky) sets on any of:
  - lbp_valid=1 outside SERVE
  - lbp_valid=1 with lbp_addr on the image border (row 0, row IMG_H-1, col 0, col IMG_W-1)
  - gray_req=1 with gray_ready=0 in LOAD
- The readback port is live in all states: rd_data<=lbp_mem[rd_addr], registered with one-cycle latency.
- load_valid outside LOAD is ignored.

## Timing
- Reset values: load_ready=1 (LOAD, on the first cycle after reset), gray_ready=0, gray_data=0, rd_data=0, wr_count=0, done=0, err=0.
- Load of a full image takes IMG_W*IMG_H accepted cycles. gray_ready rises 1 cycle after the last pixel edge.
- Read latency: 0 cycles, combinational from gray_addr. One new address per cycle, no backpressure while in SERVE.
- Write latency: lbp_mem updates at the lbp_valid edge. rd_data reflects it 1 cycle after rd_addr is presented after that edge.
- Read-during-write on the readback port (same address, same edge) returns the old data.
- Reset mid-LOAD or mid-SERVE: returns to LOAD at the next edge. A partially loaded image must be reloaded in full.

## Configuration
- LBP_SUM_EN defined: adds output lbp_sum[AW+7:0].
  - Sum of lbp_data over all accepted writes; reset to 0.
  - Updates at the same edge as wr_count.
- LBP_SUM_EN undefined: no lbp_sum port and no accumulator logic.

## Test plan
- Load 16384 pixels with value (addr mod 256) -> load_ready drops and gray_ready=1 after pixel 16383; gray_addr=300 with gray_req=1 gives gray_data=8'd44 in the same cycle.
- Load with load_valid toggling every other cycle -> gray_ready rises only after exactly 16384 accepted pixels; ld_cnt unaffected by idle cycles.
- In SERVE, write lbp_addr=129 data=8'hA5, then rd_addr=129 -> rd_data=8'hA5 one cycle later; wr_count=1.
- Write to lbp_addr=0 (border) -> err=1 and stays 1; a later valid write still stores data and counts.
- finish and lbp_valid (addr=16254, data=8'h3C) in the same cycle -> write stored, wr_count incremented, done=1 and gray_ready=0 next cycle; further lbp_valid is ignored.
- Assert reset mid-SERVE -> next cycle load_ready=1, wr_count=0, done=0, err=0; with LBP_SUM_EN, lbp_sum=0 and two writes of 8'hFF give lbp_sum=510.

Source files
------------

// File: rtl/lbp_img_mem.sv
`default_nettype none
// ============================================================================
//  Module   : lbp_img_mem
//  Purpose  : Image-side memory responder for the LBP engine. Holds one
//             IMG_W x IMG_H gray image loaded in raster order, serves the
//             engine's combinational read port, captures LBP result writes
//             and offers a registered readback port for the results.
//  Options  : LBP_SUM_EN - adds lbp_sum, the running sum of accepted codes.
//  Revision : 1.0  initial release
// ============================================================================
module lbp_img_mem #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic          gray_ready,
  output logic [7:0]    gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [7:0]    lbp_data,
  input  logic          finish,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   wr_count,
  output logic          done,
  output logic          err
`ifdef LBP_SUM_EN
  ,
  output logic [AW+7:0] lbp_sum
`endif
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int XW   = $clog2(IMG_W);

  localparam logic [AW-1:0]    LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW-XW-1:0] ROW_LAST  = (AW-XW)'(IMG_H - 1);
  localparam logic [XW-1:0]    COL_LAST  = XW'(IMG_W - 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [AW-1:0] ld_cnt;

  logic [7:0]    gray_mem [NPIX];
  logic [7:0]    lbp_mem  [NPIX];
  // Per-address "written since reset" flags; an unwritten result reads as 0,
  // which gives an instant result clear on reset without a sweep.
  logic [NPIX-1:0] lbp_vld;

  logic load_acc;
  logic wr_acc;
  logic on_border;
  logic err_set;

  assign load_acc = !reset && (state == S_LOAD) && load_valid;
  assign wr_acc   = !reset && (state == S_SERVE) && lbp_valid;

  assign on_border = (lbp_addr[AW-1:XW] == '0)       ||
                     (lbp_addr[AW-1:XW] == ROW_LAST) ||
                     (lbp_addr[XW-1:0]  == '0)       ||
                     (lbp_addr[XW-1:0]  == COL_LAST);

  assign err_set = (lbp_valid && ((state != S_SERVE) || on_border)) ||
                   (gray_req && (state == S_LOAD));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nx;
  end

  // Next-state: last pixel ends the load, finish ends serving, only reset leaves DONE.
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  if (load_valid && (ld_cnt == LAST_ADDR)) state_nx = S_SERVE;
      S_SERVE: if (finish) state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_LOAD;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    load_ready = 1'b0;
    gray_ready = 1'b0;
    done       = 1'b0;
    case (state)
      S_LOAD:  load_ready = 1'b1;
      S_SERVE: gray_ready = 1'b1;
      S_DONE:  done       = 1'b1;
      default: load_ready = 1'b0;
    endcase
  end

  // Raster load counter; wraps naturally to 0 after the last pixel.
  always_ff @(posedge clk) begin
    if (reset)         ld_cnt <= '0;
    else if (load_acc) ld_cnt <= ld_cnt + AW'(1);
  end

  // Gray image storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_acc) gray_mem[ld_cnt] <= load_data;
  end

  // Engine read port: zero-latency, gated to zero when not serving a request.
  always_comb begin
    gray_data = 8'h00;
    if (gray_ready && gray_req) gray_data = gray_mem[gray_addr];
  end

  // Result storage.
  always_ff @(posedge clk) begin
    if (wr_acc) lbp_mem[lbp_addr] <= lbp_data;
  end

  // Result valid flags, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset)       lbp_vld <= '0;
    else if (wr_acc) lbp_vld[lbp_addr] <= 1'b1;
  end

  // Registered readback; a same-edge write is not yet visible (old data).
  always_ff @(posedge clk) begin
    if (reset)                 rd_data <= 8'h00;
    else if (lbp_vld[rd_addr]) rd_data <= lbp_mem[rd_addr];
    else                       rd_data <= 8'h00;
  end

  // Accepted-write counter; repeated addresses still count.
  always_ff @(posedge clk) begin
    if (reset)       wr_count <= '0;
    else if (wr_acc) wr_count <= wr_count + (AW+1)'(1);
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (reset)        err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

`ifdef LBP_SUM_EN
  // Running sum of accepted LBP codes, in step with wr_count.
  always_ff @(posedge clk) begin
    if (reset)       lbp_sum <= '0;
    else if (wr_acc) lbp_sum <= lbp_sum + (AW+8)'(lbp_data);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lbp_img_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lbp_img_mem
//  Purpose  : Scoreboard bench for lbp_img_mem. Stimulus pushes expected
//             values into a queue; a negedge monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lbp_img_mem;

  localparam int AW   = 14;
  localparam int NPIX = 16384;

  localparam int K_LR  = 0;
  localparam int K_GR  = 1;
  localparam int K_GD  = 2;
  localparam int K_RD  = 3;
  localparam int K_WC  = 4;
  localparam int K_DN  = 5;
  localparam int K_ER  = 6;
  localparam int K_SUM = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          gray_ready;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW:0]   wr_count;
  logic          done;
  logic          err;
`ifdef LBP_SUM_EN
  logic [AW+7:0] lbp_sum;
`endif

  lbp_img_mem #(.IMG_W(128), .IMG_H(128), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_ready(gray_ready), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_count(wr_count), .done(done), .err(err)
`ifdef LBP_SUM_EN
    , .lbp_sum(lbp_sum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    int          tag;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] act(int k);
    case (k)
      K_LR:    return 32'(load_ready);
      K_GR:    return 32'(gray_ready);
      K_GD:    return 32'(gray_data);
      K_RD:    return 32'(rd_data);
      K_WC:    return 32'(wr_count);
      K_DN:    return 32'(done);
      K_ER:    return 32'(err);
`ifdef LBP_SUM_EN
      K_SUM:   return 32'(lbp_sum);
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string kname(int k);
    case (k)
      K_LR:    return "load_ready";
      K_GR:    return "gray_ready";
      K_GD:    return "gray_data";
      K_RD:    return "rd_data";
      K_WC:    return "wr_count";
      K_DN:    return "done";
      K_ER:    return "err";
      K_SUM:   return "lbp_sum";
      default: return "unknown";
    endcase
  endfunction

  // Expected value for the current cycle; sampled at the next falling edge.
  task automatic expect_now(int k, logic [31:0] v, int tag);
    exp_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.val  = v;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Monitor: compares every queued expectation due in this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = act(e.kind);
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s tag=%0d: expectation missed its sample cycle", kname(e.kind), e.tag);
      end else if (a !== e.val) begin
        bad++;
        $display("FAIL %s tag=%0d: actual=%0h required=%0h", kname(e.kind), e.tag, a, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [AW-1:0] a, logic [7:0] d);
    lbp_valid = 1'b1;
    lbp_addr  = a;
    lbp_data  = d;
    step();
    lbp_valid = 1'b0;
  endtask

  // mode 0: pixel = addr mod 256; mode 1: pixel = (3*addr) mod 256
  task automatic load_img(int mode, bit toggle, int tag);
    for (int i = 0; i < NPIX; i++) begin
      load_valid = 1'b1;
      load_data  = (mode == 0) ? 8'(i) : 8'(i * 3);
      if (i == NPIX - 1) begin
        expect_now(K_LR, 1, tag);
        expect_now(K_GR, 0, tag);
      end
      step();
      if (toggle) begin
        load_valid = 1'b0;
        load_data  = 8'hEE;
        if (i == NPIX - 2) expect_now(K_GR, 0, tag + 1);
        step();
      end
    end
    load_valid = 1'b0;
    expect_now(K_GR, 1, tag + 2);
    expect_now(K_LR, 0, tag + 2);
    step();
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; rd_addr = '0;

    // Reset state
    step(); step();
    expect_now(K_LR, 1, 1); expect_now(K_GR, 0, 1); expect_now(K_GD, 0, 1);
    expect_now(K_RD, 0, 1); expect_now(K_WC, 0, 1); expect_now(K_DN, 0, 1);
    expect_now(K_ER, 0, 1);
`ifdef LBP_SUM_EN
    expect_now(K_SUM, 0, 1);
`endif
    reset = 1'b0;
    step();

    // Continuous load, then combinational reads
    load_img(0, 1'b0, 10);
    gray_req = 1'b1; gray_addr = 14'd300;
    expect_now(K_GD, 44, 20);
    step();
    gray_addr = 14'd16383;
    expect_now(K_GD, 255, 21);
    step();
    gray_req = 1'b0; gray_addr = 14'd5;
    expect_now(K_GD, 0, 22);
    step();

    // Writes and readback (same-edge read returns old data)
    rd_addr = 14'd129;
    wr(14'd129, 8'hA5);
    expect_now(K_RD, 0, 30); expect_now(K_WC, 1, 30); expect_now(K_ER, 0, 30);
    step();
    expect_now(K_RD, 8'hA5, 31);
    wr(14'd0, 8'h11);
    expect_now(K_ER, 1, 32); expect_now(K_WC, 2, 32);
    rd_addr = 14'd130;
    wr(14'd130, 8'h5A);
    expect_now(K_ER, 1, 33); expect_now(K_WC, 3, 33);
    step();
    expect_now(K_RD, 8'h5A, 34);
    rd_addr = 14'd129;
    wr(14'd129, 8'h0F);
    expect_now(K_WC, 4, 35); expect_now(K_RD, 8'hA5, 35);
    step();
    expect_now(K_RD, 8'h0F, 36);
    rd_addr = 14'd200;
    step();
    expect_now(K_RD, 0, 37);

    // Reset mid-SERVE
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_now(K_LR, 1, 40); expect_now(K_GR, 0, 40); expect_now(K_WC, 0, 40);
    expect_now(K_DN, 0, 40); expect_now(K_ER, 0, 40);
`ifdef LBP_SUM_EN
    expect_now(K_SUM, 0, 40);
`endif
    rd_addr = 14'd129;
    step();
    expect_now(K_RD, 0, 41);

    // Read request during LOAD flags err; partial load then reset
    gray_req = 1'b1; gray_addr = 14'd0;
    expect_now(K_GD, 0, 50);
    step();
    gray_req = 1'b0;
    expect_now(K_ER, 1, 51);
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1; load_data = 8'hEE;
      step();
    end
    load_valid = 1'b0;
    expect_now(K_GR, 0, 52); expect_now(K_LR, 1, 52);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_now(K_ER, 0, 53); expect_now(K_LR, 1, 53);
    step();

    // Full reload with load_valid toggling
    load_img(1, 1'b1, 60);
    gray_req = 1'b1; gray_addr = 14'd300;
    expect_now(K_GD, 132, 70);
    step();
    gray_addr = 14'd5;
    expect_now(K_GD, 15, 71);
    step();
    gray_addr = 14'd0;
    expect_now(K_GD, 0, 72);
    step();
    gray_req = 1'b0;

    // Sum of two 0xFF writes
    wr(14'd200, 8'hFF);
    expect_now(K_WC, 1, 80); expect_now(K_ER, 0, 80);
    wr(14'd201, 8'hFF);
    expect_now(K_WC, 2, 81);
`ifdef LBP_SUM_EN
    expect_now(K_SUM, 510, 81);
`endif

    // finish with a simultaneous write
    finish = 1'b1; lbp_valid = 1'b1; lbp_addr = 14'd16254; lbp_data = 8'h3C;
    step();
    finish = 1'b0; lbp_valid = 1'b0;
    expect_now(K_DN, 1, 90); expect_now(K_GR, 0, 90); expect_now(K_LR, 0, 90);
    expect_now(K_WC, 3, 90); expect_now(K_ER, 0, 90);
`ifdef LBP_SUM_EN
    expect_now(K_SUM, 570, 90);
`endif
    rd_addr = 14'd16254;
    wr(14'd300, 8'h77);
    expect_now(K_WC, 3, 91); expect_now(K_ER, 1, 91); expect_now(K_RD, 8'h3C, 91);
`ifdef LBP_SUM_EN
    expect_now(K_SUM, 570, 91);
`endif
    rd_addr = 14'd300;
    step();
    expect_now(K_RD, 0, 92);
    gray_req = 1'b1; gray_addr = 14'd300;
    expect_now(K_GD, 0, 93);
    step();
    gray_req = 1'b0;
    step(); step();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: actual=%0d entries left required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
